digit_scan_controller: RTL and testbench
========================================

DIGIT_SCAN_CONTROLLER -- requirements
Module: digit_scan_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter PRESCALE, default 50000: clk cycles per digit slot; legal range 2..65535.
REQ-003 Parameter GUARD, default 500: anode-off cycles at the start of each slot; legal range 0..PRESCALE-1.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = scan display, 0 = display off.
REQ-007 value_in  input  16  four BCD/hex nibbles, digit k = bits [4k+3:4k].
REQ-008 load  input  1  single-cycle strobe: capture value_in.
REQ-009 blank_lz  input  1  1 = suppress leading-zero digits.
REQ-010 value  output  16  latched display value, fed downstream to nibble selection.
REQ-011 dig_sel  output  2  index of the active digit, 0 = least significant.
REQ-012 anode_n  output  4  active-low digit enables, at most one bit low.
REQ-013 frame_done  output  1  one-cycle pulse at each 3->0 digit wrap.

Function
REQ-014 State machine states: OFF, GUARD, ON; prescale counter cnt, 16 bits.
REQ-015 OFF: cnt=0, dig_sel=0, anode_n=4'hF; enable=1 -> GUARD next cycle, or ON if GUARD=0.
REQ-016 GUARD: anode_n=4'hF; cnt increments; at cnt==GUARD-1 -> ON.
REQ-017 ON: anode_n low on bit dig_sel unless blanked; cnt increments.
REQ-018 Slot end: at cnt==PRESCALE-1 in ON, cnt->0, dig_sel->dig_sel+1 mod 4 (3 wraps to 0), next state GUARD, or ON if GUARD=0; each slot is exactly PRESCALE cycles.
REQ-019 frame_done SHALL be 1 in the cycle after the 3->0 transition registers, for exactly one cycle; otherwise 0.
REQ-020 enable=0 in GUARD/ON -> OFF next cycle, cnt=0, dig_sel=0, frame_done not asserted.
REQ-021 load=1 captures value_in into pending register; a later load before transfer overwrites pending.
REQ-022 Pending transfers to value only at a frame boundary (same edge as the 3->0 wrap), so no frame mixes old and new values.
REQ-023 load coincident with the wrap edge: value_in goes directly to value on that edge.
REQ-024 load while in OFF: value updates on the next edge.
REQ-025 Leading-zero blanking: with blank_lz=1, digit k (k=1..3) is blanked when nibbles k..3 of value are all zero; digit 0 is never blanked.
REQ-026 A blanked digit keeps its slot timing, and anode_n stays 4'hF for its whole slot.
REQ-027 anode_n and frame_done SHALL be decoded only from registers, with no combinational path from any input.

Reset
REQ-028 reset=1 SHALL force immediately: state=OFF, cnt=0, dig_sel=0, anode_n=4'hF, value=16'h0000, pending cleared, frame_done=0.
REQ-029 reset asserted mid-slot or mid-frame discards pending loads; after release, scanning restarts from digit 0 with a full GUARD.

Verification
REQ-030 PRESCALE=4, GUARD=1, value=16'h1234, enable=1 -> dig_sel 0,1,2,3,0 changes every 4 cycles; each slot shows anode_n F for 1 cycle, then E/D/B/7 for 3 cycles.
REQ-031 load 16'hABCD while dig_sel=1 -> value stays 16'h1234 until the 3->0 wrap, then becomes 16'hABCD; frame_done pulses once at that boundary.
REQ-032 blank_lz=1, value=16'h0005 -> anode_n F throughout slots 1-3 and E in slot 0; value=16'h0000 -> digit 0 is still enabled.
REQ-033 load 16'h5555 on the wrap edge -> value=16'h5555 that same edge; a second load 16'h6666 in slot 2 appears only at the next wrap.
REQ-034 reset pulse during slot 2 -> all outputs reach their REQ-028 values with no clock edge; after release, scanning restarts at dig_sel=0 with anode_n F for GUARD cycles.
REQ-035 enable dropped during slot 1 -> next cycle OFF, anode_n F, dig_sel 0, no frame_done pulse.

Source files
------------

// File: rtl/digit_scan_controller.sv
// -----------------------------------------------------------------------------
// digit_scan_controller
//
// Time-multiplexes a four-digit common-anode display. Each digit owns a slot
// of PRESCALE clock cycles; the first GUARD cycles of every slot keep all
// anodes off so the downstream segment decoder can settle on the new nibble
// before the digit is lit. A new display word is loaded into a pending
// register and only promoted to the visible value at a frame boundary
// (digit 3 -> digit 0), so a single frame never mixes two words.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   enable     in   1   1 = scan, 0 = display off
//   value_in   in  16   four nibbles, digit k = value_in[4k+3:4k]
//   load       in   1   single-cycle strobe capturing value_in
//   blank_lz   in   1   1 = suppress leading-zero digits
//   value      out 16   word currently being displayed
//   dig_sel    out  2   index of the active digit, 0 = least significant
//   anode_n    out  4   active-low digit enables, at most one bit low
//   frame_done out  1   one-cycle pulse in the first cycle after a 3->0 wrap
// -----------------------------------------------------------------------------
module digit_scan_controller #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [15:0] value,
  output logic [1:0]  dig_sel,
  output logic [3:0]  anode_n,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  // Only meaningful when GUARD > 0; the guard state is never entered otherwise.
  localparam logic [15:0] GUARD_LAST    = 16'((GUARD > 0) ? GUARD - 1 : 0);
  // State entered at the start of every slot.
  localparam state_t      SLOT_START    = (GUARD == 0) ? ST_ON : ST_GUARD;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] pending;
  logic        pending_valid;

  state_t      state_d;
  logic [15:0] cnt_d;
  logic [1:0]  dig_d;
  logic        wrap;
  logic [15:0] value_d;
  logic [15:0] pending_d;
  logic        pending_valid_d;
  logic [3:0]  anode_d;

  // Digit k (k = 1..3) is a leading zero when nibbles k..3 are all zero.
  // Digit 0 is always shown so a zero word still displays "0".
  function automatic logic is_blank(input logic [1:0] dig,
                                    input logic [15:0] val,
                                    input logic blank_en);
    logic lz;
    case (dig)
      2'd1:    lz = (val[15:4]  == 12'h000);
      2'd2:    lz = (val[15:8]  == 8'h00);
      2'd3:    lz = (val[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    return blank_en && lz;
  endfunction

  // Next-state and next-output decode. Outputs are computed from the next
  // state so that, once registered, anode_n lines up with dig_sel/cnt in the
  // same cycle and has no combinational path from any input.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d         = state;
    cnt_d           = cnt;
    dig_d           = dig_sel;
    wrap            = 1'b0;
    value_d         = value;
    pending_d       = pending;
    pending_valid_d = pending_valid;
    anode_d         = 4'hF;

    case (state)
      ST_OFF: begin
        cnt_d = 16'd0;
        dig_d = 2'd0;
        if (enable) state_d = SLOT_START;
      end
      ST_GUARD: begin
        if (!enable) begin
          state_d = ST_OFF;
          cnt_d   = 16'd0;
          dig_d   = 2'd0;
        end else begin
          // cnt keeps counting through the guard so the slot length stays
          // PRESCALE regardless of GUARD.
          cnt_d = cnt + 16'd1;
          if (cnt == GUARD_LAST) state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!enable) begin
          state_d = ST_OFF;
          cnt_d   = 16'd0;
          dig_d   = 2'd0;
        end else if (cnt == PRESCALE_LAST) begin
          state_d = SLOT_START;
          cnt_d   = 16'd0;
          dig_d   = dig_sel + 2'd1;
          wrap    = (dig_sel == 2'd3);
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = 16'd0;
        dig_d   = 2'd0;
      end
    endcase

    // Nothing is on screen while off, and a frame boundary is the only safe
    // point mid-scan, so those are the two places the visible word changes.
    // A load on that same edge wins over an older pending word.
    if ((state == ST_OFF) || wrap) begin
      if (load)               value_d = value_in;
      else if (pending_valid) value_d = pending;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = value_in;
      pending_valid_d = 1'b1;
    end

    if ((state_d == ST_ON) && !is_blank(dig_d, value_d, blank_lz))
      anode_d = ~(4'b0001 << dig_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_OFF;
      cnt           <= 16'd0;
      dig_sel       <= 2'd0;
      anode_n       <= 4'hF;
      value         <= 16'h0000;
      pending       <= 16'h0000;
      pending_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state         <= state_d;
      cnt           <= cnt_d;
      dig_sel       <= dig_d;
      anode_n       <= anode_d;
      value         <= value_d;
      pending       <= pending_d;
      pending_valid <= pending_valid_d;
      frame_done    <= wrap;
    end
  end

endmodule

// File: tb/tb_digit_scan_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for digit_scan_controller (PRESCALE=4, GUARD=1).
// The reference model tracks scanning as an absolute cycle count since the
// scan started: slot = t / PRESCALE, digit = slot mod 4, guard while
// t mod PRESCALE < GUARD, frame boundary whenever t reaches a multiple of
// 4*PRESCALE. Directed steps come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_digit_scan_controller;

  localparam int P = 4;
  localparam int G = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value;
  logic [1:0]  dig_sel;
  logic [3:0]  anode_n;
  logic        frame_done;

  digit_scan_controller #(.PRESCALE(P), .GUARD(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .value      (value),
    .dig_sel    (dig_sel),
    .anode_n    (anode_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_on    = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_val   = 16'h0000;
  logic [15:0] m_pend  = 16'h0000;
  bit          m_pv    = 1'b0;
  bit          m_fd    = 1'b0;
  logic        m_blank = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int m_dig();
    return m_on ? (m_t / P) % 4 : 0;
  endfunction

  function automatic logic [3:0] m_anode();
    int  d;
    bit  lit;
    d   = m_dig();
    lit = m_on && ((m_t % P) >= G);
    // Leading zero: all nibbles from d upward are zero.
    if (m_blank && d != 0 && (m_val >> (4 * d)) == 16'h0) lit = 1'b0;
    return lit ? 4'(~(4'b0001 << d)) : 4'hF;
  endfunction

  task automatic model_reset();
    m_on = 1'b0; m_t = 0; m_val = 16'h0000; m_pend = 16'h0000;
    m_pv = 1'b0; m_fd = 1'b0; m_blank = 1'b0;
  endtask

  // One rising edge of the reference model, using the inputs held across it.
  task automatic model_edge();
    bit wrap;
    wrap    = 1'b0;
    m_blank = blank_lz;
    if (!m_on) begin
      if (load)      m_val = value_in;
      else if (m_pv) m_val = m_pend;
      m_pv = 1'b0;
      if (enable) begin m_on = 1'b1; m_t = 0; end
    end else if (!enable) begin
      m_on = 1'b0; m_t = 0;
      if (load) begin m_pend = value_in; m_pv = 1'b1; end
    end else begin
      m_t++;
      wrap = (m_t % (4 * P)) == 0;
      if (wrap) begin
        if (load)      m_val = value_in;
        else if (m_pv) m_val = m_pend;
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = value_in; m_pv = 1'b1;
      end
    end
    m_fd = wrap;
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s.value", tag), value, m_val);
    check($sformatf("%s.dig_sel", tag), 16'(dig_sel), 16'(m_dig()));
    check($sformatf("%s.anode_n", tag), 16'(anode_n), 16'(m_anode()));
    check($sformatf("%s.frame_done", tag), 16'(frame_done), 16'(m_fd));
    check($sformatf("%s.one_hot", tag), 16'($countones(~anode_n) <= 1), 16'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic step_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Advance until the model is at the given digit with scanning active.
  task automatic advance_to_dig(input int d, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * P * 3 && !found; i++) begin
      if (m_on && m_dig() == d) found = 1'b1;
      else step(tag);
    end
    check({tag, ".reached"}, 16'(found), 16'd1);
  endtask

  // Advance until the next rising edge is a frame boundary.
  task automatic advance_to_wrap_edge(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * P * 3 && !found; i++) begin
      if (m_on && enable && ((m_t + 1) % (4 * P)) == 0) found = 1'b1;
      else step(tag);
    end
    check({tag, ".reached"}, 16'(found), 16'd1);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare({tag, ".immediate"});
    @(posedge clk);
    #1;
    compare({tag, ".held"});
    #2;
    reset = 1'b0;
  endtask

  task automatic load_while_off(input logic [15:0] v, input string tag);
    enable = 1'b0;
    step({tag, ".off"});
    value_in = v; load = 1'b1;
    step({tag, ".load"});
    load = 1'b0;
    check({tag, ".direct"}, value, v);
  endtask

  initial begin
    // Reset state, observed after a clock edge with reset held.
    @(posedge clk);
    #1;
    model_reset();
    compare("reset");
    reset = 1'b0;

    // Load in OFF reaches value on the next edge, then scan 1234.
    load_while_off(16'h1234, "init");
    enable = 1'b1;
    step_n(24, "scan1234");

    // Load during digit 1 is held until the frame wraps.
    advance_to_dig(1, "to_d1");
    value_in = 16'hABCD; load = 1'b1;
    step("load_abcd");
    load = 1'b0;
    check("abcd_held", value, 16'h1234);
    step_n(16, "abcd_wrap");
    check("abcd_shown", value, 16'hABCD);

    // Load coincident with the wrap edge goes straight to value.
    advance_to_wrap_edge("to_wrap");
    value_in = 16'h5555; load = 1'b1;
    step("load_on_wrap");
    load = 1'b0;
    check("wrap_direct", value, 16'h5555);
    check("wrap_pulse", 16'(frame_done), 16'd1);
    advance_to_dig(2, "to_d2");
    value_in = 16'h6666; load = 1'b1;
    step("load_6666");
    load = 1'b0;
    check("6666_held", value, 16'h5555);
    step_n(12, "6666_wrap");

    // Leading-zero blanking: 0005, then 0000 still lights digit 0.
    blank_lz = 1'b1;
    load_while_off(16'h0005, "lz5");
    enable = 1'b1;
    step_n(20, "lz5_scan");
    load_while_off(16'h0000, "lz0");
    enable = 1'b1;
    step_n(20, "lz0_scan");
    blank_lz = 1'b0;
    load_while_off(16'h1234, "restore");
    enable = 1'b1;

    // Reset in the middle of digit 2 with a pending load outstanding.
    advance_to_dig(2, "to_rst");
    value_in = 16'h9999; load = 1'b1;
    step("pend_before_rst");
    load = 1'b0;
    async_reset("rst_mid");
    step_n(20, "after_rst");

    // Enable dropped during digit 1.
    load_while_off(16'h4321, "pre_drop");
    enable = 1'b1;
    advance_to_dig(1, "to_drop");
    enable = 1'b0;
    step("drop");
    step_n(3, "dropped");
    enable = 1'b1;
    step_n(8, "reenable");

    // Randomized phase.
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      value_in = v;
      enable   = ($urandom_range(0, 24) != 0);
      load     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      else step("rand");
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
